// File: rtl/lut_cfg_writer.sv
// Serial-to-parallel loader for LUT truth tables: shifts in a framed, even-parity
// protected bit stream under valid/ready and atomically commits it to a registered bus.
module lut_cfg_writer #(
    parameter  int NUM_LUT = 3,
    parameter  int LUT_W   = 4,
    localparam int PAY_W   = NUM_LUT * LUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             s_valid,
    input  logic             s_data,
    output logic             s_ready,
    output logic [PAY_W-1:0] lut_cfg,
    output logic             cfg_valid,
    output logic             busy,
    output logic             cfg_done,
    output logic             cfg_err
);

    localparam int CNT_W = $clog2(PAY_W) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [CNT_W-1:0]   bit_cnt_r;
    logic [PAY_W-1:0]   shadow_r;
    logic [PAY_W-1:0]   lut_cfg_r;
    logic               cfg_valid_r;
    logic               s_ready_r;
    logic               busy_r;
    logic               cfg_done_r;
    logic               cfg_err_r;
    logic               beat_s;

    // Even parity over payload plus the trailing parity bit must be zero.
    function automatic logic parity_ok(input logic [PAY_W-1:0] payload, input logic p);
        return ~((^payload) ^ p);
    endfunction

    assign s_ready   = s_ready_r;
    assign lut_cfg   = lut_cfg_r;
    assign cfg_valid = cfg_valid_r;
    assign busy      = busy_r;
    assign cfg_done  = cfg_done_r;
    assign cfg_err   = cfg_err_r;

    // Abort wins over a beat in the same cycle, so the bit stays with the sender.
    assign beat_s = s_valid && s_ready_r && !abort;

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && !abort) begin
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (abort) begin
                    next_state_s = IDLE;
                end else if (beat_s && (bit_cnt_r == CNT_W'(PAY_W - 1))) begin
                    next_state_s = PARITY;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            PARITY: begin
                if (abort) begin
                    next_state_s = IDLE;
                end else if (beat_s) begin
                    next_state_s = COMMIT;
                end else begin
                    next_state_s = PARITY;
                end
            end
            COMMIT: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, shadow shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            bit_cnt_r   <= '0;
            shadow_r    <= '0;
            lut_cfg_r   <= '0;
            cfg_valid_r <= 1'b0;
            s_ready_r   <= 1'b0;
            busy_r      <= 1'b0;
            cfg_done_r  <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            s_ready_r  <= (next_state_s == SHIFT) || (next_state_s == PARITY);
            busy_r     <= (next_state_s != IDLE);
            cfg_done_r <= 1'b0;
            cfg_err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start && !abort) begin
                        bit_cnt_r   <= '0;
                        shadow_r    <= '0;
                        cfg_valid_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    // Right shift: after PAY_W beats the first (LSB) bit lands in bit 0.
                    if (beat_s) begin
                        shadow_r  <= {s_data, shadow_r[PAY_W-1:1]};
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (beat_s) begin
                        if (parity_ok(shadow_r, s_data)) begin
                            lut_cfg_r   <= shadow_r;
                            cfg_valid_r <= 1'b1;
                            cfg_done_r  <= 1'b1;
                        end else begin
                            cfg_err_r   <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    bit_cnt_r <= bit_cnt_r;
                end
                default: begin
                    bit_cnt_r <= '0;
                end
            endcase
        end
    end

endmodule
